// File: rtl/sr_deser_ctrl.sv
// Serial-in deserialiser controller: frames WIDTH bits into a held parallel word
// with valid/ready on both sides. Define SR_DESER_PARITY_EN for a trailing even-parity bit.
module sr_deser_ctrl #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          x_i,
  input  logic                          x_vld_i,
  output logic                          x_rdy_o,
  input  logic                          abort_i,
  output logic [WIDTH-1:0]              word_o,
  output logic                          word_vld_o,
  input  logic                          word_rdy_i,
  output logic                          par_err_o,
  output logic [$clog2(WIDTH+2)-1:0]    bit_cnt_o
);

  localparam int CW = $clog2(WIDTH+2);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
`ifdef SR_DESER_PARITY_EN
    PAR   = 2'd2,
`endif
    FULL  = 2'd3
  } state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] sreg, sreg_n, shifted, load_word;
  logic [CW-1:0]    cnt, cnt_n;
  logic             accept, consume, hold_free, load;
  logic [WIDTH-1:0] word_q;
  logic             word_vld_q;
`ifdef SR_DESER_PARITY_EN
  logic             par_acc, par_acc_n, load_err, par_err_q;
`endif

  assign x_rdy_o    = (state != FULL);
  assign accept     = x_vld_i && x_rdy_o && !abort_i;
  assign consume    = word_vld_q && word_rdy_i;
  // A finished frame may load if the holding slot is empty or emptying now.
  assign hold_free  = !word_vld_q || consume;
  assign word_o     = word_q;
  assign word_vld_o = word_vld_q;
  assign bit_cnt_o  = cnt;
`ifdef SR_DESER_PARITY_EN
  assign par_err_o  = par_err_q;
`else
  assign par_err_o  = 1'b0;
`endif

  always_comb begin
    if (MSB_FIRST) shifted = {sreg[WIDTH-2:0], x_i};
    else           shifted = {x_i, sreg[WIDTH-1:1]};
  end

  always_comb begin
    state_n   = state;
    sreg_n    = sreg;
    cnt_n     = cnt;
    load      = 1'b0;
    load_word = sreg;
`ifdef SR_DESER_PARITY_EN
    par_acc_n = par_acc;
    load_err  = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (accept) begin
          sreg_n  = shifted;
          cnt_n   = CW'(1);
          state_n = SHIFT;
`ifdef SR_DESER_PARITY_EN
          par_acc_n = x_i;
`endif
        end
      end
      SHIFT: begin
        if (abort_i) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else if (accept) begin
          sreg_n = shifted;
          cnt_n  = cnt + CW'(1);
`ifdef SR_DESER_PARITY_EN
          par_acc_n = par_acc ^ x_i;
          if (cnt == CW'(WIDTH-1)) state_n = PAR;
`else
          if (cnt == CW'(WIDTH-1)) begin
            if (hold_free) begin
              load      = 1'b1;
              load_word = shifted;
              state_n   = IDLE;
              cnt_n     = '0;
            end else begin
              state_n = FULL;
            end
          end
`endif
        end
      end
`ifdef SR_DESER_PARITY_EN
      PAR: begin
        if (abort_i) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else if (accept) begin
          // In FULL, par_acc carries the finished frame's error flag.
          par_acc_n = par_acc ^ x_i;
          load_err  = par_acc ^ x_i;
          if (hold_free) begin
            load    = 1'b1;
            state_n = IDLE;
            cnt_n   = '0;
          end else begin
            state_n = FULL;
            cnt_n   = cnt + CW'(1);
          end
        end
      end
`endif
      FULL: begin
        if (abort_i) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else if (consume) begin
          load    = 1'b1;
          state_n = IDLE;
          cnt_n   = '0;
`ifdef SR_DESER_PARITY_EN
          load_err = par_acc;
`endif
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      sreg       <= '0;
      cnt        <= '0;
      word_q     <= '0;
      word_vld_q <= 1'b0;
`ifdef SR_DESER_PARITY_EN
      par_acc    <= 1'b0;
      par_err_q  <= 1'b0;
`endif
    end else begin
      state <= state_n;
      sreg  <= sreg_n;
      cnt   <= cnt_n;
`ifdef SR_DESER_PARITY_EN
      par_acc <= par_acc_n;
`endif
      if (load) begin
        word_q     <= load_word;
        word_vld_q <= 1'b1;
`ifdef SR_DESER_PARITY_EN
        par_err_q  <= load_err;
`endif
      end else if (consume) begin
        word_vld_q <= 1'b0;
`ifdef SR_DESER_PARITY_EN
        par_err_q  <= 1'b0;
`endif
      end
    end
  end

endmodule

// File: tb/tb_sr_deser_ctrl.sv
// Directed bench for sr_deser_ctrl (WIDTH=4): one MSB-first and one LSB-first
// instance share the same stimulus; parity scenarios follow SR_DESER_PARITY_EN.
module tb_sr_deser_ctrl;

`ifdef SR_DESER_PARITY_EN
  localparam logic [2:0] FULL_CNT = 3'd5;
`else
  localparam logic [2:0] FULL_CNT = 3'd4;
`endif

  logic       clk, reset, x, x_vld, abort, word_rdy;
  logic       rdy_m, vld_m, perr_m, rdy_l, vld_l, perr_l;
  logic [3:0] word_m, word_l;
  logic [2:0] cnt_m, cnt_l;
  int         n_pass = 0;
  int         n_total = 0;

  sr_deser_ctrl #(.WIDTH(4), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .reset(reset), .x_i(x), .x_vld_i(x_vld), .x_rdy_o(rdy_m),
    .abort_i(abort), .word_o(word_m), .word_vld_o(vld_m), .word_rdy_i(word_rdy),
    .par_err_o(perr_m), .bit_cnt_o(cnt_m));

  sr_deser_ctrl #(.WIDTH(4), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .reset(reset), .x_i(x), .x_vld_i(x_vld), .x_rdy_o(rdy_l),
    .abort_i(abort), .word_o(word_l), .word_vld_o(vld_l), .word_rdy_i(word_rdy),
    .par_err_o(perr_l), .bit_cnt_o(cnt_l));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Bits go out left to right; the parity build appends the even-parity bit.
  task automatic send_frame(input logic [3:0] bits);
    for (int i = 3; i >= 0; i--) begin
      x = bits[i]; x_vld = 1'b1; cyc();
    end
`ifdef SR_DESER_PARITY_EN
    x = ^bits; x_vld = 1'b1; cyc();
`endif
    x_vld = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; cyc(); cyc();
    n_total++; if (rdy_m !== 1'b1) $display("[TB] FAIL reset_rdy got %b want 1", rdy_m); else n_pass++;
    n_total++; if (vld_m !== 1'b0) $display("[TB] FAIL reset_vld got %b want 0", vld_m); else n_pass++;
    n_total++; if (word_m !== 4'b0000) $display("[TB] FAIL reset_word got %b want 0000", word_m); else n_pass++;
    n_total++; if (cnt_m !== 3'd0) $display("[TB] FAIL reset_cnt got %0d want 0", cnt_m); else n_pass++;
    n_total++; if (perr_m !== 1'b0) $display("[TB] FAIL reset_perr got %b want 0", perr_m); else n_pass++;
    n_total++; if ({rdy_l, vld_l, perr_l, cnt_l, word_l} !== {1'b1, 1'b0, 1'b0, 3'd0, 4'd0})
      $display("[TB] FAIL reset_lsb got %b want 1000000000", {rdy_l, vld_l, perr_l, cnt_l, word_l}); else n_pass++;
    reset = 1'b0;
  endtask

  task automatic test_basic();
    word_rdy = 1'b1;
    x = 1'b1; x_vld = 1'b1; cyc();
    x = 1'b0; cyc();
    n_total++; if (cnt_m !== 3'd2) $display("[TB] FAIL basic_cnt2 got %0d want 2", cnt_m); else n_pass++;
    n_total++; if (vld_m !== 1'b0) $display("[TB] FAIL basic_early_vld got %b want 0", vld_m); else n_pass++;
    x = 1'b1; cyc();
    x = 1'b1; cyc();
`ifdef SR_DESER_PARITY_EN
    n_total++; if (vld_m !== 1'b0) $display("[TB] FAIL basic_vld_before_par got %b want 0", vld_m); else n_pass++;
    x = 1'b1; cyc();
`endif
    x_vld = 1'b0;
    n_total++; if (vld_m !== 1'b1) $display("[TB] FAIL basic_vld got %b want 1", vld_m); else n_pass++;
    n_total++; if (word_m !== 4'b1011) $display("[TB] FAIL basic_word_msb got %b want 1011", word_m); else n_pass++;
    n_total++; if (word_l !== 4'b1101 || vld_l !== 1'b1) $display("[TB] FAIL basic_word_lsb got %b/%b want 1101/1", word_l, vld_l); else n_pass++;
    n_total++; if (cnt_m !== 3'd0) $display("[TB] FAIL basic_cnt_done got %0d want 0", cnt_m); else n_pass++;
    n_total++; if (perr_m !== 1'b0) $display("[TB] FAIL basic_perr got %b want 0", perr_m); else n_pass++;
    cyc();
    n_total++; if (vld_m !== 1'b0) $display("[TB] FAIL basic_vld_drop got %b want 0", vld_m); else n_pass++;
  endtask

  task automatic test_backpressure();
    word_rdy = 1'b0;
    send_frame(4'b1010);
    n_total++; if (vld_m !== 1'b1 || word_m !== 4'b1010) $display("[TB] FAIL bp_first got %b/%b want 1/1010", vld_m, word_m); else n_pass++;
    send_frame(4'b0110);
    n_total++; if (rdy_m !== 1'b0) $display("[TB] FAIL bp_rdy_low got %b want 0", rdy_m); else n_pass++;
    n_total++; if (cnt_m !== FULL_CNT) $display("[TB] FAIL bp_cnt_full got %0d want %0d", cnt_m, FULL_CNT); else n_pass++;
    x = 1'b1; x_vld = 1'b1; cyc();
    x_vld = 1'b0;
    n_total++; if (cnt_m !== FULL_CNT || rdy_m !== 1'b0) $display("[TB] FAIL bp_frozen got %0d/%b want %0d/0", cnt_m, rdy_m, FULL_CNT); else n_pass++;
    n_total++; if (word_m !== 4'b1010) $display("[TB] FAIL bp_word_stable got %b want 1010", word_m); else n_pass++;
    word_rdy = 1'b1; cyc();
    word_rdy = 1'b0;
    n_total++; if (word_m !== 4'b0110 || vld_m !== 1'b1) $display("[TB] FAIL bp_second got %b/%b want 0110/1", word_m, vld_m); else n_pass++;
    n_total++; if (rdy_m !== 1'b1 || cnt_m !== 3'd0) $display("[TB] FAIL bp_release got %b/%0d want 1/0", rdy_m, cnt_m); else n_pass++;
    n_total++; if (word_l !== 4'b0110) $display("[TB] FAIL bp_second_lsb got %b want 0110", word_l); else n_pass++;
    cyc();
    n_total++; if (vld_m !== 1'b1 || word_m !== 4'b0110) $display("[TB] FAIL bp_hold got %b/%b want 1/0110", vld_m, word_m); else n_pass++;
    word_rdy = 1'b1; cyc();
    n_total++; if (vld_m !== 1'b0) $display("[TB] FAIL bp_drain got %b want 0", vld_m); else n_pass++;
  endtask

  task automatic test_abort();
    word_rdy = 1'b1;
    x = 1'b1; x_vld = 1'b1; cyc(); cyc();
    abort = 1'b1; cyc();
    abort = 1'b0; x_vld = 1'b0;
    n_total++; if (cnt_m !== 3'd0 || vld_m !== 1'b0) $display("[TB] FAIL abort_clear got %0d/%b want 0/0", cnt_m, vld_m); else n_pass++;
    send_frame(4'b0001);
    n_total++; if (word_m !== 4'b0001 || vld_m !== 1'b1) $display("[TB] FAIL abort_word got %b/%b want 0001/1", word_m, vld_m); else n_pass++;
    n_total++; if (word_l !== 4'b1000) $display("[TB] FAIL abort_word_lsb got %b want 1000", word_l); else n_pass++;
    cyc();
    x = 1'b1; x_vld = 1'b1; cyc(); cyc();
    reset = 1'b1; x_vld = 1'b0; cyc();
    n_total++; if ({rdy_m, vld_m, perr_m, cnt_m, word_m} !== {1'b1, 1'b0, 1'b0, 3'd0, 4'd0})
      $display("[TB] FAIL reset_mid got %b want 1000000000", {rdy_m, vld_m, perr_m, cnt_m, word_m}); else n_pass++;
    reset = 1'b0;
    send_frame(4'b0001);
    n_total++; if (word_m !== 4'b0001 || vld_m !== 1'b1) $display("[TB] FAIL reset_mid_word got %b/%b want 0001/1", word_m, vld_m); else n_pass++;
    cyc();
  endtask

  task automatic test_abort_full();
    word_rdy = 1'b0;
    send_frame(4'b1100);
    send_frame(4'b0011);
    n_total++; if (rdy_m !== 1'b0) $display("[TB] FAIL abf_rdy_low got %b want 0", rdy_m); else n_pass++;
    abort = 1'b1; cyc();
    abort = 1'b0;
    n_total++; if (rdy_m !== 1'b1 || cnt_m !== 3'd0) $display("[TB] FAIL abf_idle got %b/%0d want 1/0", rdy_m, cnt_m); else n_pass++;
    n_total++; if (vld_m !== 1'b1 || word_m !== 4'b1100) $display("[TB] FAIL abf_hold got %b/%b want 1/1100", vld_m, word_m); else n_pass++;
    word_rdy = 1'b1; cyc();
    n_total++; if (vld_m !== 1'b0) $display("[TB] FAIL abf_discard got %b want 0", vld_m); else n_pass++;
  endtask

  task automatic test_gaps();
    word_rdy = 1'b1;
    x = 1'b1; x_vld = 1'b1; cyc();
    x = 1'b0; cyc();
    x_vld = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      n_total++; if (cnt_m !== 3'd2) $display("[TB] FAIL gap_cnt%0d got %0d want 2", i, cnt_m); else n_pass++;
    end
    x = 1'b1; x_vld = 1'b1; cyc();
    cyc();
`ifdef SR_DESER_PARITY_EN
    cyc();
`endif
    x_vld = 1'b0;
    n_total++; if (word_m !== 4'b1011 || vld_m !== 1'b1) $display("[TB] FAIL gap_word got %b/%b want 1011/1", word_m, vld_m); else n_pass++;
    n_total++; if (word_l !== 4'b1101) $display("[TB] FAIL gap_word_lsb got %b want 1101", word_l); else n_pass++;
    cyc();
  endtask

  task automatic test_back_to_back();
    word_rdy = 1'b1;
    send_frame(4'b0101);
    n_total++; if (word_m !== 4'b0101 || vld_m !== 1'b1) $display("[TB] FAIL b2b_first got %b/%b want 0101/1", word_m, vld_m); else n_pass++;
    n_total++; if (rdy_m !== 1'b1) $display("[TB] FAIL b2b_rdy got %b want 1", rdy_m); else n_pass++;
    send_frame(4'b1110);
    n_total++; if (word_m !== 4'b1110 || vld_m !== 1'b1) $display("[TB] FAIL b2b_second got %b/%b want 1110/1", word_m, vld_m); else n_pass++;
    n_total++; if (word_l !== 4'b0111) $display("[TB] FAIL b2b_second_lsb got %b want 0111", word_l); else n_pass++;
    cyc();
  endtask

`ifdef SR_DESER_PARITY_EN
  task automatic test_parity();
    word_rdy = 1'b1;
    x_vld = 1'b1;
    x = 1'b1; cyc(); x = 1'b0; cyc(); x = 1'b1; cyc(); x = 1'b1; cyc();
    x = 1'b0; cyc();
    x_vld = 1'b0;
    n_total++; if (perr_m !== 1'b1 || vld_m !== 1'b1) $display("[TB] FAIL par_bad got %b/%b want 1/1", perr_m, vld_m); else n_pass++;
    n_total++; if (word_m !== 4'b1011) $display("[TB] FAIL par_bad_word got %b want 1011", word_m); else n_pass++;
    cyc();
    n_total++; if (perr_m !== 1'b0 || vld_m !== 1'b0) $display("[TB] FAIL par_clear got %b/%b want 0/0", perr_m, vld_m); else n_pass++;
    send_frame(4'b1011);
    n_total++; if (perr_m !== 1'b0 || vld_m !== 1'b1) $display("[TB] FAIL par_good got %b/%b want 0/1", perr_m, vld_m); else n_pass++;
    cyc();
  endtask
`endif

  initial begin
    reset = 1'b1; x = 1'b0; x_vld = 1'b0; abort = 1'b0; word_rdy = 1'b0;
    test_reset();
    test_basic();
    test_backpressure();
    test_abort();
    test_abort_full();
    test_gaps();
    test_back_to_back();
`ifdef SR_DESER_PARITY_EN
    test_parity();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
